dc_diff_encoder: RTL and testbench

//  DC DPCM stage of the JPEG encoder, directly upstream of the DC luminance/chrominance

---
 rtl/dc_diff_if.sv | 39 +++
 rtl/dc_diff_encoder.sv | 92 +++++++++
 tb/tb_dc_diff_encoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dc_diff_if.sv
// dc_diff_if: quantizer-to-encoder DC beat stream and encoded output stream.
// With DC_RESTART_EN defined, also carries restart_intv and enc_rst_flag.
interface dc_diff_if #(
   parameter int COEFF_W = 11
);
   localparam int CW = $clog2(COEFF_W + 1);
   logic                      frame_start;
   logic                      dc_vld;
   logic                      dc_rdy;
   logic signed [COEFF_W-1:0] dc_coeff;
   logic [1:0]                dc_comp;
   logic                      dc_mcu_last;
   logic                      enc_vld;
   logic                      enc_rdy;
   logic [CW-1:0]             extra_bits;
   logic [COEFF_W-1:0]        amp_bits;
   logic [1:0]                enc_comp;
   logic                      enc_mcu_last;
`ifdef DC_RESTART_EN
   logic [15:0]               restart_intv;
   logic                      enc_rst_flag;
`endif
   modport master (
`ifdef DC_RESTART_EN
      output restart_intv,
      input  enc_rst_flag,
`endif
      output frame_start, dc_vld, dc_coeff, dc_comp, dc_mcu_last, enc_rdy,
      input  dc_rdy, enc_vld, extra_bits, amp_bits, enc_comp, enc_mcu_last
   );
   modport slave (
`ifdef DC_RESTART_EN
      input  restart_intv,
      output enc_rst_flag,
`endif
      input  frame_start, dc_vld, dc_coeff, dc_comp, dc_mcu_last, enc_rdy,
      output dc_rdy, enc_vld, extra_bits, amp_bits, enc_comp, enc_mcu_last
   );
endinterface

// File: rtl/dc_diff_encoder.sv
// dc_diff_encoder: JPEG DC DPCM stage emitting size category and amplitude bits.
// DC_RESTART_EN adds restart-interval predictor resets (restart_intv in, enc_rst_flag out).
module dc_diff_encoder #(
   parameter int NCOMP   = 3,
   parameter int COEFF_W = 11
) (
   input logic      clk,
   input logic      rst,
   dc_diff_if.slave bus
);
   localparam int DW = COEFF_W + 1;
   localparam int CW = $clog2(COEFF_W + 1);
   logic signed [COEFF_W-1:0] pred [NCOMP];
   logic signed [COEFF_W-1:0] pred_sel;
   logic signed [DW-1:0]      diff;
   logic [DW-1:0]             mag;
   logic [COEFF_W-1:0]        adj;
   logic [COEFF_W-1:0]        amp;
   logic [CW-1:0]             cat;
   logic                      accept;
   logic                      hit;
   logic                      vld_q;
   logic                      last_q;
   logic [CW-1:0]             cat_q;
   logic [COEFF_W-1:0]        amp_q;
   logic [1:0]                comp_q;
   assign bus.dc_rdy       = !vld_q | bus.enc_rdy;
   assign accept           = bus.dc_vld & bus.dc_rdy;
   assign bus.enc_vld      = vld_q;
   assign bus.extra_bits   = cat_q;
   assign bus.amp_bits     = amp_q;
   assign bus.enc_comp     = comp_q;
   assign bus.enc_mcu_last = last_q;
`ifdef DC_RESTART_EN
   logic [15:0] mcu_cnt;
   logic [15:0] mcu_nxt;
   logic        flag_q;
   // frame_start clears the count before the coincident beat is counted
   assign mcu_nxt = (bus.frame_start ? 16'd0 : mcu_cnt) + 16'd1;
   assign hit = accept & bus.dc_mcu_last & (bus.restart_intv != 16'd0) & (mcu_nxt == bus.restart_intv);
   assign bus.enc_rst_flag = flag_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mcu_cnt <= '0;
         flag_q  <= 1'b0;
      end else begin
         if (accept & bus.dc_mcu_last) mcu_cnt <= hit ? 16'd0 : mcu_nxt;
         else if (bus.frame_start) mcu_cnt <= '0;
         if (accept) flag_q <= hit;
      end
`else
   assign hit = 1'b0;
`endif
   // out-of-range components and frame_start both predict from zero
   always_comb begin
      pred_sel = '0;
      for (int i = 0; i < NCOMP; i++)
         pred_sel = (int'(bus.dc_comp) == i && !bus.frame_start) ? pred[i] : pred_sel;
      diff = {bus.dc_coeff[COEFF_W-1], bus.dc_coeff} - {pred_sel[COEFF_W-1], pred_sel};
      mag  = diff[DW-1] ? -diff : diff;
      cat  = '0;
      for (int i = 0; i < DW; i++)
         cat = mag[i] ? CW'(i + 1) : cat;
      adj = diff[COEFF_W-1:0] - COEFF_W'(diff[DW-1]);
      amp = '0;
      for (int i = 0; i < COEFF_W; i++)
         amp[i] = (i < int'(cat)) & adj[i];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < NCOMP; i++) pred[i] <= '0;
      else
         for (int i = 0; i < NCOMP; i++)
            if (hit) pred[i] <= '0;
            else if (accept && int'(bus.dc_comp) == i) pred[i] <= bus.dc_coeff;
            else if (bus.frame_start) pred[i] <= '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld_q  <= 1'b0;
         cat_q  <= '0;
         amp_q  <= '0;
         comp_q <= '0;
         last_q <= 1'b0;
      end else if (accept) begin
         vld_q  <= 1'b1;
         cat_q  <= cat;
         amp_q  <= amp;
         comp_q <= bus.dc_comp;
         last_q <= bus.dc_mcu_last;
      end else if (bus.enc_rdy)
         vld_q <= 1'b0;
endmodule

// File: tb/tb_dc_diff_encoder.sv
// tb_dc_diff_encoder: randomized scoreboard bench for dc_diff_encoder against an arithmetic DPCM model.
// Exercises the restart-interval path as well when DC_RESTART_EN is defined.
module tb_dc_diff_encoder;
   localparam int NCOMP = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dc_diff_if #(.COEFF_W(11)) bus ();
   dc_diff_encoder #(.NCOMP(NCOMP), .COEFF_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {int cat; int amp; int comp; int last; int flag;} exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int pred[NCOMP];
   int mcnt = 0;
   int intv = 0;
   bit rdy_mode = 1'b0;
   bit rdy_force = 1'b1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic void model_clear();
      foreach (pred[i]) pred[i] = 0;
      mcnt = 0;
   endfunction
   function automatic exp_t model(int coeff, int comp, bit last);
      exp_t e;
      int p, d, a;
      p = comp < NCOMP ? pred[comp] : 0;
      d = coeff - p;
      if (comp < NCOMP) pred[comp] = coeff;
      a = d < 0 ? -d : d;
      e.cat = 0;
      while (a > 0) begin
         e.cat++;
         a = a >> 1;
      end
      e.amp = e.cat == 0 ? 0 : ((d > 0 ? d : d - 1) & ((1 << e.cat) - 1));
      e.comp = comp;
      e.last = last;
      e.flag = 0;
      if (last) begin
         mcnt++;
         if (intv != 0 && mcnt == intv) begin
            e.flag = 1;
            mcnt = 0;
            foreach (pred[i]) pred[i] = 0;
         end
      end
      return e;
   endfunction
   task automatic idle(int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic pulse_fs();
      bus.frame_start = 1'b1;
      model_clear();
      idle(1);
      bus.frame_start = 1'b0;
   endtask
   task automatic send(int coeff, int comp, bit last, bit fs = 1'b0, int xcat = -1, int xamp = -1);
      exp_t e;
      int n;
      bus.dc_vld = 1'b1;
      bus.dc_coeff = 11'(coeff);
      bus.dc_comp = 2'(comp);
      bus.dc_mcu_last = last;
      bus.frame_start = fs;
      if (fs) model_clear();
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.dc_rdy === 1'b1) break;
         if (++n > 200) begin
            errors++;
            $display("FAIL accept timeout: dc_rdy stuck at %0b", bus.dc_rdy);
            $fatal(1, "input stalled");
         end
         @(posedge clk);
         #1 bus.frame_start = 1'b0;
      end
      e = model(coeff, comp, last);
      if (xcat >= 0) begin
         e.cat = xcat;
         e.amp = xamp;
      end
      sb.push_back(e);
      idle(1);
      bus.dc_vld = 1'b0;
      bus.frame_start = 1'b0;
   endtask
   initial begin
      bus.enc_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1 bus.enc_rdy = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.enc_vld === 1'b1) begin
            if (sb.size() == 0) chk("unexpected beat", 1, 0);
            else if (bus.enc_rdy) begin
               e = sb.pop_front();
               chk("extra_bits", bus.extra_bits, e.cat);
               chk("amp_bits", bus.amp_bits, e.amp);
               chk("enc_comp", bus.enc_comp, e.comp);
               chk("enc_mcu_last", bus.enc_mcu_last, e.last);
`ifdef DC_RESTART_EN
               chk("enc_rst_flag", bus.enc_rst_flag, e.flag);
`endif
            end else begin
               chk("stall dc_rdy", bus.dc_rdy, 0);
               chk("hold extra_bits", bus.extra_bits, sb[0].cat);
               chk("hold amp_bits", bus.amp_bits, sb[0].amp);
               chk("hold enc_comp", bus.enc_comp, sb[0].comp);
            end
         end
      end
   end
   initial begin
      #3_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      bus.dc_vld = 1'b0;
      bus.frame_start = 1'b0;
      bus.dc_coeff = '0;
      bus.dc_comp = '0;
      bus.dc_mcu_last = 1'b0;
`ifdef DC_RESTART_EN
      bus.restart_intv = '0;
`endif
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst enc_vld", bus.enc_vld, 0);
      chk("rst extra_bits", bus.extra_bits, 0);
      chk("rst amp_bits", bus.amp_bits, 0);
      chk("rst enc_comp", bus.enc_comp, 0);
      chk("rst enc_mcu_last", bus.enc_mcu_last, 0);
`ifdef DC_RESTART_EN
      chk("rst enc_rst_flag", bus.enc_rst_flag, 0);
`endif
      @(negedge clk) rst = 1'b0;
      idle(1);
      send(-1, 0, 1'b1, 1'b0, 1, 0);
      send(-1024, 0, 1'b1, 1'b0, 10, 0);
      pulse_fs();
      send(5, 0, 1'b1, 1'b0, 3, 5);
      send(5, 0, 1'b1, 1'b0, 0, 0);
      send(3, 0, 1'b1, 1'b0, 2, 1);
      pulse_fs();
      send(1023, 0, 1'b1, 1'b0, 10, 'h3FF);
      send(-1024, 0, 1'b1, 1'b0, 11, 0);
      pulse_fs();
      send(10, 0, 1'b0, 1'b0, 4, 10);
      send(-4, 1, 1'b0, 1'b0, 3, 3);
      send(7, 2, 1'b1, 1'b0, 3, 7);
      send(12, 0, 1'b0, 1'b0, 2, 2);
      send(5, 3, 1'b0, 1'b0, 3, 5);
      send(5, 3, 1'b0, 1'b0, 3, 5);
      send(6, 0, 1'b1, 1'b1, 3, 6);
      rdy_force = 1'b0;
      idle(2);
      send(100, 1, 1'b0);
      fork
         send(50, 2, 1'b1);
         begin
            idle(4);
            rdy_force = 1'b1;
         end
      join
`ifdef DC_RESTART_EN
      intv = 2;
      bus.restart_intv = 16'd2;
      pulse_fs();
      send(8, 0, 1'b1, 1'b0, 4, 8);
      send(8, 0, 1'b1, 1'b0, 0, 0);
      send(8, 0, 1'b1, 1'b0, 4, 8);
      intv = 3;
      bus.restart_intv = 16'd3;
`endif
      rdy_mode = 1'b1;
      pulse_fs();
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send(int'($urandom_range(0, 2047)) - 1024, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      end
      rdy_mode = 1'b0;
      rdy_force = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         idle(1);
         n++;
      end
      chk("drain queue", sb.size(), 0);
      rdy_force = 1'b0;
      idle(2);
      send(77, 0, 1'b0);
      idle(1);
      chk("pending before rst", bus.enc_vld, 1);
      rst = 1'b1;
      #1;
      chk("rst flush enc_vld", bus.enc_vld, 0);
      chk("rst flush amp_bits", bus.amp_bits, 0);
      sb.delete();
      model_clear();
      @(negedge clk) rst = 1'b0;
      rdy_force = 1'b1;
      idle(2);
      send(3, 0, 1'b1, 1'b0, 2, 3);
      idle(3);
      chk("final queue", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
